// File: rtl/fpu_sched_pkg.sv
// Shared types and constants for the FPU request scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpu_sched_pkg;

  // Bit positions inside the 8-bit FPU flag vector
  localparam int FLG_INF  = 7;
  localparam int FLG_SNAN = 6;
  localparam int FLG_QNAN = 5;
  localparam int FLG_INE  = 4;
  localparam int FLG_OVF  = 3;
  localparam int FLG_UNF  = 2;
  localparam int FLG_ZERO = 1;
  localparam int FLG_DBZ  = 0;

  // FPU opcodes the clients normally use; other codes pass through untouched
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;

  // Tag id is sized for the largest supported requester count (8)
  localparam int TAG_ID_W = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} req_state_e;

endpackage

// File: rtl/fpu_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority starts at an internal pointer.
// Latency: grant is combinational; pointer advances on the grant edge.
// Backpressure: none; an empty request vector yields a zero grant and the pointer holds.
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic [W-1:0] winner
);

  logic [W-1:0] ptr_q;

  // Scan requesters starting at the pointer, wrapping modulo N; first one wins
  always_comb begin
    logic [W:0] idx;
    logic       found;
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_q} + (W+1)'(k);
      if (idx >= (W+1)'(N)) idx = idx - (W+1)'(N);
      if (!found && req[idx[W-1:0]]) begin
        found               = 1'b1;
        grant[idx[W-1:0]]   = 1'b1;
        winner              = idx[W-1:0];
      end
    end
  end

  // Pointer moves just past the winner so it gets lowest priority next time
  always_ff @(posedge clk) begin
    if (!rst_n)
      ptr_q <= '0;
    else if (|grant)
      ptr_q <= (winner == W'(N-1)) ? '0 : winner + 1'b1;
  end

endmodule

// File: rtl/fpu_scheduler.sv
// Shares one pipelined FPU between N_REQ requesters with round-robin issue and tagged writeback.
// Latency: response valid LAT+1 cycles after the grant cycle; one issue per cycle.
// Backpressure: one outstanding op per requester; a held response blocks that requester's next grant.
module fpu_scheduler
  import fpu_sched_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int LAT   = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*32-1:0] req_opa,
  input  logic [N_REQ*32-1:0] req_opb,
  input  logic [N_REQ*3-1:0]  req_op,
  input  logic [N_REQ*2-1:0]  req_rmode,
  output logic [31:0]         fpu_opa,
  output logic [31:0]         fpu_opb,
  output logic [2:0]          fpu_op,
  output logic [1:0]          fpu_rmode,
  input  logic [31:0]         fpu_out,
  input  logic [7:0]          fpu_flags,
  output logic [N_REQ-1:0]    resp_valid,
  input  logic [N_REQ-1:0]    resp_ready,
  output logic [N_REQ*32-1:0] resp_out,
  output logic [N_REQ*8-1:0]  resp_flags,
  output logic [ID_W:0]       in_flight
);

  logic [31:0]      opa_a [N_REQ];
  logic [31:0]      opb_a [N_REQ];
  logic [2:0]       op_a  [N_REQ];
  logic [1:0]       rm_a  [N_REQ];
  logic [31:0]      res_q [N_REQ];
  logic [7:0]       flg_q [N_REQ];
  req_state_e       state_q [N_REQ];
  req_state_e       state_d [N_REQ];
  tag_t             tag_q [LAT];
  logic [N_REQ-1:0] elig, grant, wb_hit;
  logic [ID_W-1:0]  winner;
  logic             issue, wb;

  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    assign opa_a[i]               = req_opa[i*32 +: 32];
    assign opb_a[i]               = req_opb[i*32 +: 32];
    assign op_a[i]                = req_op[i*3 +: 3];
    assign rm_a[i]                = req_rmode[i*2 +: 2];
    assign elig[i]                = rst_n && req_valid[i] && (state_q[i] == IDLE);
    assign wb_hit[i]              = tag_q[LAT-1].valid && (tag_q[LAT-1].id == TAG_ID_W'(i));
    assign resp_valid[i]          = (state_q[i] == DONE);
    assign resp_out[i*32 +: 32]   = res_q[i];
    assign resp_flags[i*8 +: 8]   = flg_q[i];
  end

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (elig),
    .grant  (grant),
    .winner (winner)
  );

  assign req_ready = grant;
  assign issue     = |grant;
  assign wb        = tag_q[LAT-1].valid;

  // Launch the winner's operands into the FPU; hold the port when nobody is granted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fpu_opa   <= '0;
      fpu_opb   <= '0;
      fpu_op    <= '0;
      fpu_rmode <= '0;
    end else if (issue) begin
      fpu_opa   <= opa_a[winner];
      fpu_opb   <= opb_a[winner];
      fpu_op    <= op_a[winner];
      fpu_rmode <= rm_a[winner];
    end
  end

  // Tag shift register tracks who owns each FPU pipeline slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < LAT; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= {issue, TAG_ID_W'(winner)};
      for (int s = 1; s < LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  // Capture the FPU result into the owner's response holding register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        res_q[i] <= '0;
        flg_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (wb_hit[i]) begin
          res_q[i] <= fpu_out;
          flg_q[i] <= fpu_flags;
        end
      end
    end
  end

  // Occupancy of the tag pipeline; issue and writeback in one cycle cancel
  always_ff @(posedge clk) begin
    if (!rst_n)
      in_flight <= '0;
    else if (issue && !wb)
      in_flight <= in_flight + 1'b1;
    else if (!issue && wb)
      in_flight <= in_flight - 1'b1;
  end

  // Per-requester state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) state_q[i] <= IDLE;
    end else begin
      for (int i = 0; i < N_REQ; i++) state_q[i] <= state_d[i];
    end
  end

  // Per-requester lifecycle: granted -> in FPU -> response held -> accepted
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        IDLE:    if (grant[i])      state_d[i] = BUSY;
        BUSY:    if (wb_hit[i])     state_d[i] = DONE;
        DONE:    if (resp_ready[i]) state_d[i] = IDLE;
        default:                    state_d[i] = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_scheduler.sv
// Bench for fpu_scheduler: stand-in FPU, transaction-level reference model, directed and random traffic.
module tb_fpu_scheduler;
  import fpu_sched_pkg::*;

  localparam int N   = 4;
  localparam int LAT = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [N-1:0]     req_valid, req_ready, resp_valid, resp_ready;
  logic [N*32-1:0]  req_opa, req_opb, resp_out;
  logic [N*3-1:0]   req_op;
  logic [N*2-1:0]   req_rmode;
  logic [N*8-1:0]   resp_flags;
  logic [31:0]      fpu_opa, fpu_opb, fpu_out;
  logic [2:0]       fpu_op;
  logic [1:0]       fpu_rmode;
  logic [7:0]       fpu_flags;
  logic [IDW:0]     in_flight;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  fpu_scheduler #(.N_REQ(N), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opa(req_opa), .req_opb(req_opb), .req_op(req_op), .req_rmode(req_rmode),
    .fpu_opa(fpu_opa), .fpu_opb(fpu_opb), .fpu_op(fpu_op), .fpu_rmode(fpu_rmode),
    .fpu_out(fpu_out), .fpu_flags(fpu_flags),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_out(resp_out), .resp_flags(resp_flags),
    .in_flight(in_flight)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stand-in FPU: exact answers for the directed cases, a deterministic scramble otherwise
  function automatic logic [39:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op, input logic [1:0] rm);
    logic [31:0] r;
    logic [7:0]  f;
    if (op == OP_ADD && a == 32'h3F80_0000 && b == 32'h3F80_0000) return {8'h00, 32'h4000_0000};
    if (op == OP_DIV && b == 32'h0) return {8'h81, 32'h7F80_0000};
    r = (a ^ {b[15:0], b[31:16]}) + {27'd0, op, rm};
    f = a[7:0] ^ b[15:8] ^ {3'b0, op, rm};
    return {f, r};
  endfunction

  // FPU result appears on the LAT-th cycle of the operands being presented
  logic [39:0] fpipe [LAT-1];
  always @(posedge clk) begin
    fpipe[0] <= fpu_fn(fpu_opa, fpu_opb, fpu_op, fpu_rmode);
    for (int k = 1; k < LAT-1; k++) fpipe[k] <= fpipe[k-1];
  end
  assign {fpu_flags, fpu_out} = fpipe[LAT-2];

  // Reference model: per requester, "outstanding" plus the cycle its answer is due
  bit          m_out [N];
  int          m_ret [N];
  logic [31:0] m_res [N];
  logic [7:0]  m_flg [N];
  int          m_ptr = 0;
  int          cyc = 0;

  always @(negedge clk) begin
    logic [N-1:0] exp_rdy, exp_vld;
    int win, idx, exp_if;
    bit found;
    if (chk_en) begin
      exp_rdy = '0; exp_vld = '0; found = 1'b0; win = 0; exp_if = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && rst_n && req_valid[idx] && !m_out[idx]) begin
          found = 1'b1; win = idx; exp_rdy[idx] = 1'b1;
        end
      end
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
      for (int i = 0; i < N; i++) begin
        exp_vld[i] = m_out[i] && (cyc >= m_ret[i]);
        if (m_out[i] && cyc < m_ret[i]) exp_if++;
      end
      check("resp_valid", 64'(resp_valid), 64'(exp_vld));
      check("in_flight", 64'(in_flight), 64'(exp_if));
      for (int i = 0; i < N; i++) begin
        if (exp_vld[i]) begin
          check("resp_out", 64'(resp_out[i*32 +: 32]), 64'(m_res[i]));
          check("resp_flags", 64'(resp_flags[i*8 +: 8]), 64'(m_flg[i]));
        end
      end
      if (!rst_n) begin
        for (int i = 0; i < N; i++) m_out[i] = 1'b0;
        m_ptr = 0;
      end else begin
        for (int i = 0; i < N; i++)
          if (exp_vld[i] && resp_ready[i]) m_out[i] = 1'b0;
        if (found) begin
          m_out[win] = 1'b1;
          m_ret[win] = cyc + LAT + 1;
          {m_flg[win], m_res[win]} = fpu_fn(req_opa[win*32 +: 32], req_opb[win*32 +: 32],
                                            req_op[win*3 +: 3], req_rmode[win*2 +: 2]);
          m_ptr = (win + 1) % N;
        end
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_opa[i*32 +: 32] = $urandom;
      req_opb[i*32 +: 32] = $urandom;
      req_op[i*3 +: 3]    = 3'($urandom_range(0, 7));
      req_rmode[i*2 +: 2] = 2'($urandom_range(0, 3));
    end
  endtask

  initial begin
    int others, held;
    rst_n = 1'b0; req_valid = '0; resp_ready = '0;
    req_opa = '0; req_opb = '0; req_op = '0; req_rmode = '0;
    for (int i = 0; i < N; i++) m_out[i] = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1; chk_en = 1'b1;
    @(negedge clk);
    check("rst_in_flight", 64'(in_flight), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_fpu_opa", 64'(fpu_opa), 64'd0);
    check("rst_resp_out", 64'(resp_out), 64'd0);

    // Requester 0: 1.0 + 1.0
    tick();
    req_valid = 4'b0001;
    req_opa[31:0] = 32'h3F80_0000; req_opb[31:0] = 32'h3F80_0000;
    req_op[2:0] = OP_ADD; req_rmode[1:0] = 2'd0;
    @(negedge clk); check("a_grant", 64'(req_ready), 64'h1);
    tick(); req_valid = '0;
    repeat (LAT-1) tick();
    @(negedge clk); check("a_not_early", 64'(resp_valid), 64'h0);
    tick();
    @(negedge clk);
    check("a_valid", 64'(resp_valid), 64'h1);
    check("a_out", 64'(resp_out[31:0]), 64'h4000_0000);
    check("a_flags", 64'(resp_flags[7:0]), 64'h00);
    tick(); resp_ready = '1;
    tick(); resp_ready = '0;

    // Requester 1: 1.0 / 0.0
    req_valid = 4'b0010;
    req_opa[63:32] = 32'h3F80_0000; req_opb[63:32] = 32'h0;
    req_op[5:3] = OP_DIV; req_rmode[3:2] = 2'd0;
    @(negedge clk); check("b_grant", 64'(req_ready), 64'h2);
    tick(); req_valid = '0;
    repeat (LAT) tick();
    @(negedge clk);
    check("b_valid", 64'(resp_valid), 64'h2);
    check("b_out", 64'(resp_out[63:32]), 64'h7F80_0000);
    check("b_dbz", 64'(resp_flags[8+FLG_DBZ]), 64'h1);
    check("b_inf", 64'(resp_flags[8+FLG_INF]), 64'h1);
    tick(); resp_ready = '1;
    tick(); resp_ready = '0;

    // All four valid straight out of reset
    rst_n = 1'b0;
    tick(); rst_n = 1'b1; rand_ops(); req_valid = '1;
    for (int k = 0; k < N; k++) begin
      @(negedge clk); check("c_grant_order", 64'(req_ready), 64'(1 << k));
      tick();
    end
    @(negedge clk); check("c_in_flight_peak", 64'(in_flight), 64'd4);
    tick(); req_valid = '0; resp_ready = '1;
    for (int k = 0; k < N; k++) begin
      @(negedge clk); check("c_resp_order", 64'(resp_valid), 64'(1 << k));
      tick();
    end
    resp_ready = '0;

    // Pointer wrap: grant 2 so the pointer sits at 3, then request 0 and 3
    req_valid = 4'b0100;
    @(negedge clk); check("e_pre", 64'(req_ready), 64'h4);
    tick(); req_valid = 4'b1001;
    @(negedge clk); check("e_wrap_first", 64'(req_ready), 64'h8);
    tick();
    @(negedge clk); check("e_wrap_second", 64'(req_ready), 64'h1);
    tick(); req_valid = '0; resp_ready = '1;
    repeat (LAT+3) tick();

    // Requester 2 stalls its response while the others keep flowing
    others = 0; held = 0;
    for (int n = 0; n < 32; n++) begin
      tick();
      rand_ops();
      req_valid = 4'($urandom) | 4'b0100;
      resp_ready = 4'($urandom | $urandom) & 4'b1011;
      @(negedge clk);
      if ((req_ready & 4'b1011) != 0) others++;
      if (resp_valid[2]) held++;
    end
    check("d_others_served", 64'(others >= 4), 64'd1);
    check("d_held_long", 64'(held >= 20), 64'd1);
    tick(); req_valid = '0; resp_ready = '1;
    repeat (LAT+4) tick();

    // Reset with three operations inside the FPU
    resp_ready = '0; rand_ops(); req_valid = 4'b0111;
    repeat (3) tick();
    req_valid = '0; rst_n = 1'b0;
    @(negedge clk); check("f_in_flight_before", 64'(in_flight), 64'd3);
    tick(); rst_n = 1'b1;
    for (int k = 0; k < LAT+2; k++) begin
      @(negedge clk);
      check("f_no_resp", 64'(resp_valid), 64'h0);
      check("f_in_flight_zero", 64'(in_flight), 64'd0);
      tick();
    end
    req_valid = '1;
    @(negedge clk); check("f_first_grant", 64'(req_ready), 64'h1);

    // Random traffic with occasional resets
    for (int n = 0; n < 1500; n++) begin
      tick();
      rand_ops();
      req_valid  = 4'($urandom);
      resp_ready = 4'($urandom);
      rst_n      = ($urandom_range(0, 63) != 0);
    end
    tick(); rst_n = 1'b1; req_valid = '0; resp_ready = '1;
    repeat (LAT+6) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
